// File: rtl/feeder_pkg.sv
//------------------------------------------------------------------------------
// Module  : feeder_pkg
// Brief   : Shared constants for the MAC operand feeder and its MAC core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package feeder_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    localparam int         STATE_W = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/feeder_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : feeder_addr_gen
// Brief   : Clearable issue counter driving buffer ce/address, flags last issue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module feeder_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_issue,
    input  logic [ADDR_WIDTH:0]   i_num,
    output logic                  o_ce,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] r_issue_cnt;
    logic                w_last_issue;

    // Counter is one bit wider than the address so N = 2**ADDR_WIDTH never wraps.
    assign w_last_issue = (r_issue_cnt == (i_num - c_one));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt <= '0;
            o_ce        <= 1'b0;
            o_addr      <= '0;
            o_last      <= 1'b0;
        end else if (i_clr) begin
            r_issue_cnt <= '0;
            o_ce        <= 1'b0;
            o_last      <= 1'b0;
        end else if (i_issue) begin
            o_ce        <= 1'b1;
            o_addr      <= r_issue_cnt[ADDR_WIDTH-1:0];
            o_last      <= w_last_issue;
            r_issue_cnt <= r_issue_cnt + c_one;
        end else begin
            o_ce        <= 1'b0;
            o_last      <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
//------------------------------------------------------------------------------
// Module  : mac_operand_feeder
// Brief   : Clears the MAC, streams N operand pairs from the buffers, captures
//           the final sum. Optional perf counter under FEEDER_PERF_CNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_operand_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH:0]     i_num,
    output logic                    o_idle,
    output logic                    o_node_ce,
    output logic [ADDR_WIDTH-1:0]   o_node_addr,
    input  logic [DATA_WIDTH-1:0]   i_node_q,
    output logic                    o_wegt_ce,
    output logic [ADDR_WIDTH-1:0]   o_wegt_addr,
    input  logic [DATA_WIDTH-1:0]   i_wegt_q,
    output logic                    o_run,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_node,
    output logic [DATA_WIDTH-1:0]   o_wegt,
    input  logic                    i_mac_valid,
    input  logic [4*DATA_WIDTH-1:0] i_mac_result,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [4*DATA_WIDTH-1:0] o_res_data,
    output logic [31:0]             o_cycle_cnt
);

    localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [STATE_W-1:0]  r_state;
    logic [ADDR_WIDTH:0] r_num;
    logic [ADDR_WIDTH:0] r_ret_cnt;
    logic                w_accept;
    logic                w_issue;
    logic                w_last;

    assign w_accept = (r_state == S_IDLE) && i_start;
    // CLEAR issues address 0 so reads begin the cycle after the o_run pulse.
    assign w_issue  = (r_state == S_CLEAR) || ((r_state == S_FEED) && !w_last);

    feeder_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_accept),
        .i_issue (w_issue),
        .i_num   (r_num),
        .o_ce    (o_node_ce),
        .o_addr  (o_node_addr),
        .o_last  (w_last)
    );

    assign o_wegt_ce   = o_node_ce;
    assign o_wegt_addr = o_node_addr;
    assign o_node      = i_node_q;
    assign o_wegt      = i_wegt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_ret_cnt   <= '0;
            o_idle      <= 1'b1;
            o_run       <= 1'b0;
            o_valid     <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
        end else begin
            o_run   <= 1'b0;
            o_valid <= o_node_ce;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_idle <= 1'b0;
                        if (i_num != '0) begin
                            r_num     <= i_num;
                            r_ret_cnt <= '0;
                            o_run     <= 1'b1;
                            r_state   <= S_CLEAR;
                        end else begin
                            o_res_data  <= '0;
                            o_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    r_ret_cnt <= '0;
                    r_state   <= S_FEED;
                end
                S_FEED: begin
                    if (i_mac_valid) begin
                        r_ret_cnt <= r_ret_cnt + c_one;
                    end
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_mac_valid) begin
                        r_ret_cnt <= r_ret_cnt + c_one;
                        if (r_ret_cnt == (r_num - c_one)) begin
                            o_res_data  <= i_mac_result;
                            o_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_idle      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    o_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;

    // The accept cycle counts as the first, so the value reads N+5 as o_res_valid rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_accept) begin
            r_cycle_cnt <= 32'd1;
        end else if ((r_state != S_IDLE) && !o_res_valid) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`else
    assign o_cycle_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
//------------------------------------------------------------------------------
// Module  : tb_mac_operand_feeder
// Brief   : Feeder paired with a 2-cycle MAC model and 1-cycle operand buffers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_operand_feeder;

    localparam int DW = 8;
    localparam int AW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_start;
    logic [AW:0]    i_num;
    logic           o_idle;
    logic           o_node_ce;
    logic [AW-1:0]  o_node_addr;
    logic [DW-1:0]  node_q;
    logic           o_wegt_ce;
    logic [AW-1:0]  o_wegt_addr;
    logic [DW-1:0]  wegt_q;
    logic           o_run;
    logic           o_valid;
    logic [DW-1:0]  o_node;
    logic [DW-1:0]  o_wegt;
    logic           mac_valid;
    logic [4*DW-1:0] mac_result;
    logic           o_res_valid;
    logic           i_res_ready;
    logic [4*DW-1:0] o_res_data;
    logic [31:0]    o_cycle_cnt;

    mac_operand_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_num(i_num), .o_idle(o_idle),
        .o_node_ce(o_node_ce), .o_node_addr(o_node_addr), .i_node_q(node_q),
        .o_wegt_ce(o_wegt_ce), .o_wegt_addr(o_wegt_addr), .i_wegt_q(wegt_q),
        .o_run(o_run), .o_valid(o_valid), .o_node(o_node), .o_wegt(o_wegt),
        .i_mac_valid(mac_valid), .i_mac_result(mac_result),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_cycle_cnt(o_cycle_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] node_mem [0:255];
    logic [DW-1:0] wegt_mem [0:255];

    always @(posedge clk) begin
        if (o_node_ce) node_q <= node_mem[o_node_addr];
        if (o_wegt_ce) wegt_q <= wegt_mem[o_wegt_addr];
    end

    // Two-stage MAC: multiply, then accumulate; o_run clears the accumulator.
    logic [2*DW-1:0] prod;
    logic            v1;
    always @(posedge clk) begin
        if (reset) begin
            prod <= '0; v1 <= 1'b0; mac_valid <= 1'b0; mac_result <= '0;
        end else begin
            prod      <= o_node * o_wegt;
            v1        <= o_valid;
            mac_valid <= v1;
            if (o_run) mac_result <= '0;
            else if (v1) mac_result <= mac_result + {16'd0, prod};
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint exp_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(node_mem[i]) * longint'(wegt_mem[i]);
        return s & 64'hFFFF_FFFF;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            node_mem[i] = 8'($urandom);
            wegt_mem[i] = 8'($urandom);
        end
    endtask

    task automatic run_vec(input int n, input int hold);
        int     cyc, runs, ces, vals, aerr;
        longint es;
        int     lat;
        es  = exp_sum(n);
        lat = (n == 0) ? 1 : n + 5;
        @(negedge clk); i_start = 1'b1; i_num = n[AW:0];
        @(negedge clk); i_start = 1'b0;
        cyc = 1; runs = 0; ces = 0; vals = 0; aerr = 0;
        while (!o_res_valid && cyc < 1000) begin
            if (o_run) runs++;
            if (o_valid) vals++;
            if (o_node_ce) begin
                if (o_node_addr != ces[AW-1:0] || o_wegt_addr != o_node_addr || !o_wegt_ce) aerr++;
                ces++;
            end
            @(negedge clk); cyc++;
        end
        chk("latency", cyc, lat);
        chk("res_data", o_res_data, es);
        chk("run_pulses", runs, (n > 0) ? 1 : 0);
        chk("reads", ces, n);
        chk("valids", vals, n);
        chk("addr_seq_err", aerr, 0);
`ifdef FEEDER_PERF_CNT_EN
        chk("cycle_cnt", o_cycle_cnt, lat);
`else
        chk("cycle_cnt", o_cycle_cnt, 0);
`endif
        for (int h = 0; h < hold; h++) begin
            i_start = (h % 3 == 0);
            i_num   = 9'd5;
            @(negedge clk);
            chk("hold_valid", o_res_valid, 1);
            chk("hold_data", o_res_data, es);
        end
        i_start = 1'b0;
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        chk("back_idle", o_idle, 1);
        chk("back_valid", o_res_valid, 0);
    endtask

    initial begin
        reset = 1'b1; i_start = 1'b0; i_num = '0; i_res_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin node_mem[i] = '0; wegt_mem[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_idle", o_idle, 1);
        chk("rst_ce", o_node_ce, 0);
        chk("rst_run", o_run, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res_data", o_res_data, 0);
        chk("rst_cycle_cnt", o_cycle_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin node_mem[i] = 8'(i + 1); wegt_mem[i] = 8'(i + 5); end
        chk("dir_model_70", exp_sum(4), 70);
        run_vec(4, 0);
        run_vec(0, 0);

        for (int i = 0; i < 256; i++) begin node_mem[i] = 8'd255; wegt_mem[i] = 8'd255; end
        run_vec(256, 0);

        fill_rand();
        run_vec(10, 10);
        fill_rand();
        run_vec(7, 3);
        repeat (6) begin
            fill_rand();
            run_vec($urandom_range(1, 60), $urandom_range(0, 4));
        end

        fill_rand();
        @(negedge clk); i_start = 1'b1; i_num = 9'd8;
        @(negedge clk); i_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_idle", o_idle, 1);
        chk("mid_rst_ce", o_node_ce, 0);
        chk("mid_rst_addr", o_node_addr, 0);
        chk("mid_rst_run", o_run, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_res_valid", o_res_valid, 0);
        chk("mid_rst_res_data", o_res_data, 0);
        chk("mid_rst_cycle_cnt", o_cycle_cnt, 0);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_result", o_res_valid, 0);
        run_vec(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
